// File: rtl/switch_mcu_ahb_pkg.sv
// Shared encodings for the MCU AHB-Lite master arbiter: bus constants, FSM states, owner id
// and the registered transfer descriptor.
package switch_mcu_ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [3:0] HPROT_FETCH   = 4'b0010;
  localparam logic [3:0] HPROT_DATA    = 4'b0011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } owner_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic        lock;
  } xfer_t;

endpackage

// File: rtl/switch_mcu_arb_fair.sv
// IFU/LSU grant select: LSU-first with a bounded run of LSU grants while the IFU waits,
// plus lock stickiness. Combinational grant, registered history; no backpressure of its own.
module switch_mcu_arb_fair
  import switch_mcu_ahb_pkg::*;
#(
  parameter int LSU_MAX_CONSEC = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic arb_en,
  input  logic ifu_req,
  input  logic lsu_req,
  input  logic lsu_lock,
  output logic grant_vld,
  output logic grant_owner
);

  localparam logic [3:0] CNT_MAX = 4'(LSU_MAX_CONSEC);

  logic [3:0] lsu_cnt;
  logic       lock_hist;
  logic       cnt_sat;
  logic       lsu_win;

  assign cnt_sat = (lsu_cnt == CNT_MAX);

  // A held lock keeps the bus with the LSU even when the IFU has been starved.
  always_comb begin
    lsu_win     = lsu_req & (lock_hist | ~(ifu_req & cnt_sat));
    grant_vld   = arb_en & (ifu_req | lsu_req);
    grant_owner = lsu_win ? OWN_LSU : OWN_IFU;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lsu_cnt   <= 4'd0;
      lock_hist <= 1'b0;
    end else if (grant_vld) begin
      if (grant_owner == OWN_IFU) begin
        lsu_cnt   <= 4'd0;
        lock_hist <= 1'b0;
      end else begin
        if (ifu_req && !cnt_sat) begin
          lsu_cnt <= lsu_cnt + 4'd1;
        end
        lock_hist <= lsu_lock;
      end
    end
  end

endmodule

// File: rtl/switch_mcu_ahb_arbiter.sv
// Shares one AHB-Lite master port between IFU and LSU with single non-pipelined transfers.
// Latency 4 cycles per transfer at zero wait; hready low in ADDR/DATA stalls one cycle each.
// Requesters hold req until their done pulse; requests are only examined in IDLE.
module switch_mcu_ahb_arbiter
  import switch_mcu_ahb_pkg::*;
#(
  parameter int LSU_MAX_CONSEC = 4
) (
  input  logic        in_clk,
  input  logic        in_rst,
  input  logic        in_ifu_req,
  input  logic [31:0] in_ifu_addr,
  output logic        out_ifu_done,
  output logic        out_ifu_err,
  output logic [31:0] out_ifu_rdata,
  input  logic        in_lsu_req,
  input  logic [31:0] in_lsu_addr,
  input  logic        in_lsu_write,
  input  logic [2:0]  in_lsu_size,
  input  logic [31:0] in_lsu_wdata,
  input  logic        in_lsu_lock,
  output logic        out_lsu_done,
  output logic        out_lsu_err,
  output logic [31:0] out_lsu_rdata,
  input  logic        in_hready,
  input  logic        in_hresp,
  input  logic [31:0] in_hrdata,
  output logic [31:0] out_haddr,
  output logic        out_hwrite,
  output logic [2:0]  out_hsize,
  output logic [2:0]  out_hburst,
  output logic [3:0]  out_hprot,
  output logic [1:0]  out_htrans,
  output logic        out_hmastlock,
  output logic [31:0] out_hwdata
);

  arb_state_t  state_q, state_d;
  owner_t      owner_q;
  xfer_t       xfer_q, xfer_d;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        grant_vld;
  logic        grant_owner;

  switch_mcu_arb_fair #(
    .LSU_MAX_CONSEC(LSU_MAX_CONSEC)
  ) u_fair (
    .clk        (in_clk),
    .rst        (in_rst),
    .arb_en     (state_q == ST_IDLE),
    .ifu_req    (in_ifu_req),
    .lsu_req    (in_lsu_req),
    .lsu_lock   (in_lsu_lock),
    .grant_vld  (grant_vld),
    .grant_owner(grant_owner)
  );

  // Fetches are normalised to word reads at grant so the address phase just replays xfer_q.
  always_comb begin
    xfer_d = '0;
    if (grant_owner == OWN_LSU) begin
      xfer_d.addr  = in_lsu_addr;
      xfer_d.write = in_lsu_write;
      xfer_d.size  = in_lsu_size;
      xfer_d.wdata = in_lsu_wdata;
      xfer_d.lock  = in_lsu_lock;
    end else begin
      xfer_d.addr  = in_ifu_addr;
      xfer_d.write = 1'b0;
      xfer_d.size  = HSIZE_WORD;
    end
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_IFU;
      xfer_q  <= '0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && grant_vld) begin
        owner_q <= owner_t'(grant_owner);
        xfer_q  <= xfer_d;
      end
      if (state_q == ST_DATA && in_hready) begin
        rdata_q <= in_hrdata;
        err_q   <= in_hresp;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    out_haddr     = 32'd0;
    out_hwrite    = 1'b0;
    out_hsize     = 3'b000;
    out_hburst    = HBURST_SINGLE;
    out_hprot     = 4'b0000;
    out_htrans    = HTRANS_IDLE;
    out_hmastlock = 1'b0;
    out_hwdata    = 32'd0;
    out_ifu_done  = 1'b0;
    out_ifu_err   = 1'b0;
    out_ifu_rdata = 32'd0;
    out_lsu_done  = 1'b0;
    out_lsu_err   = 1'b0;
    out_lsu_rdata = 32'd0;

    unique case (state_q)
      ST_IDLE: begin
        if (grant_vld) begin
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        out_htrans    = HTRANS_NONSEQ;
        out_haddr     = xfer_q.addr;
        out_hwrite    = xfer_q.write;
        out_hsize     = xfer_q.size;
        out_hprot     = (owner_q == OWN_LSU) ? HPROT_DATA : HPROT_FETCH;
        out_hmastlock = (owner_q == OWN_LSU) & xfer_q.lock;
        if (in_hready) begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        out_hwdata    = xfer_q.wdata;
        out_hmastlock = (owner_q == OWN_LSU) & xfer_q.lock;
        if (in_hready) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (owner_q == OWN_LSU) begin
          out_lsu_done  = 1'b1;
          out_lsu_err   = err_q;
          out_lsu_rdata = rdata_q;
        end else begin
          out_ifu_done  = 1'b1;
          out_ifu_err   = err_q;
          out_ifu_rdata = rdata_q;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule
